// File: rtl/id_pkg.sv
// Shared decode constants and ID/EX bundle for the id_pipe stage.
// Opcode map, control FSM states and the packed EX control bundle.
package id_pkg;

   localparam logic [3:0] OP_LW  = 4'b1000;
   localparam logic [3:0] OP_SW  = 4'b1001;
   localparam logic [3:0] OP_JAL = 4'b1101;
   localparam logic [3:0] OP_JR  = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   // Width-independent part of the ID/EX bundle; operands and dst
   // are parametrised and live beside it in id_pipe.
   typedef struct packed {
      logic        valid;
      logic [15:0] link;
      logic [7:0]  imm8;
      logic [3:0]  shamt;
      logic [2:0]  func;
      logic        src1sel;
      logic        we_rf;
      logic        we_mem;
      logic        re_mem;
      logic        wb_sel;
      logic        hlt;
   } id_ex_t;

   function automatic logic [15:0] sext12(input logic [11:0] v);
      return {{4{v[11]}}, v};
   endfunction

endpackage

// File: rtl/id_regfile.sv
// NREG x DATA_W register file, two combinational read ports.
// R0 is hardwired to zero; reads see a same-cycle WB write.
module id_regfile
   import id_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREG   = 16,
   localparam int AW    = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [AW-1:0]     wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [AW-1:0]     ra0,
   output logic [DATA_W-1:0] rd0,
   input  logic [AW-1:0]     ra1,
   output logic [DATA_W-1:0] rd1
);

   logic [DATA_W-1:0] mem [NREG];
   logic              wr_ok;

   assign wr_ok = we && (wa != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_ok) begin
         mem[wa] <= wd;
      end
   end

   always_comb begin
      rd0 = mem[ra0];
      rd1 = mem[ra1];
      if (wr_ok && wa == ra0) rd0 = wd;
      if (wr_ok && wa == ra1) rd1 = wd;
      if (ra0 == '0) rd0 = '0;
      if (ra1 == '0) rd1 = '0;
   end

endmodule

// File: rtl/id_pipe.sv
// Instruction decode stage: decode, operand read, hazard stall,
// jump resolution, halt sequencing and the ID/EX register.
module id_pipe
   import id_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREG   = 16,
   localparam int AW    = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_valid,
   input  logic [15:0]       if_instr,
   input  logic [15:0]       if_pc,
   output logic              stall,
   output logic              j_ctrl,
   output logic [15:0]       j_pc,
   input  logic              wb_we,
   input  logic [AW-1:0]     wb_dst,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              wb_hlt,
   input  logic              mem_we,
   input  logic [AW-1:0]     mem_dst,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_p0,
   output logic [DATA_W-1:0] ex_p1,
   output logic [15:0]       ex_link,
   output logic [7:0]        ex_imm8,
   output logic [3:0]        ex_shamt,
   output logic [2:0]        ex_func,
   output logic              ex_src1sel,
   output logic              ex_we_rf,
   output logic              ex_we_mem,
   output logic              ex_re_mem,
   output logic              ex_wb_sel,
   output logic              ex_hlt,
   output logic [AW-1:0]     ex_dst,
   output logic              halted
);

   state_t            state;
   id_ex_t            ex_q, ex_d;
   logic [DATA_W-1:0] p0_q, p1_q;
   logic [AW-1:0]     dst_q, dst_d;

   logic [3:0]        op, rd, rs, rt;
   logic [AW-1:0]     rd_a, rs_a, rt_a;
   logic [DATA_W-1:0] rs_val, rt_val;
   logic              is_lw, is_sw, is_jal, is_jr;
   logic              is_hlt, is_alu;
   logic              rs_used, rt_used, rs_nz, rt_nz;
   logic              lu_haz, jr_haz, issue;

   assign op   = if_instr[15:12];
   assign rd   = if_instr[11:8];
   assign rs   = if_instr[7:4];
   assign rt   = if_instr[3:0];
   assign rd_a = AW'(rd);
   assign rs_a = AW'(rs);
   assign rt_a = AW'(rt);

   id_regfile #(
      .DATA_W (DATA_W),
      .NREG   (NREG)
   ) u_rf (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wb_we),
      .wa    (wb_dst),
      .wd    (wb_data),
      .ra0   (rs_a),
      .rd0   (rs_val),
      .ra1   (rt_a),
      .rd1   (rt_val)
   );

   always_comb begin
      is_lw  = 1'b0;
      is_sw  = 1'b0;
      is_jal = 1'b0;
      is_jr  = 1'b0;
      is_hlt = 1'b0;
      is_alu = 1'b0;
      unique case (op)
         OP_LW:   is_lw  = 1'b1;
         OP_SW:   is_sw  = 1'b1;
         OP_JAL:  is_jal = 1'b1;
         OP_JR:   is_jr  = 1'b1;
         OP_HLT:  is_hlt = 1'b1;
         default: is_alu = 1'b1;
      endcase
   end

   assign rs_used = is_alu | is_lw | is_sw | is_jr;
   assign rt_used = is_alu | is_sw;
   assign rs_nz   = (rs_a != '0);
   assign rt_nz   = (rt_a != '0);

   // A WB-stage writer is already visible through the regfile bypass.
   assign lu_haz = ex_q.valid & ex_q.re_mem &
                   ((rs_used & rs_nz & (dst_q == rs_a)) |
                    (rt_used & rt_nz & (dst_q == rt_a)));
   assign jr_haz = is_jr & rs_nz &
                   ((ex_q.valid & ex_q.we_rf & (dst_q == rs_a)) |
                    (mem_we & (mem_dst == rs_a)));

   assign stall  = (state != ST_RUN) |
                   (if_valid & (lu_haz | jr_haz));
   assign issue  = if_valid & ~stall;
   assign j_ctrl = issue & (is_jal | is_jr);
   assign j_pc   = is_jal ? if_pc + sext12(if_instr[11:0])
                          : rs_val[15:0];

   always_comb begin
      ex_d         = '0;
      ex_d.valid   = issue;
      ex_d.link    = if_pc + 16'd1;
      ex_d.imm8    = if_instr[7:0];
      ex_d.shamt   = rt;
      ex_d.func    = is_alu ? op[2:0] : 3'd0;
      ex_d.src1sel = is_lw | is_sw;
      ex_d.we_rf   = issue & (is_alu | is_lw | is_jal);
      ex_d.we_mem  = issue & is_sw;
      ex_d.re_mem  = issue & is_lw;
      ex_d.wb_sel  = is_lw;
      ex_d.hlt     = issue & is_hlt;
      dst_d        = is_jal ? AW'(NREG - 1) : rd_a;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         p0_q  <= '0;
         p1_q  <= '0;
         dst_q <= '0;
      end else begin
         ex_q  <= ex_d;
         p0_q  <= rs_val;
         p1_q  <= rt_val;
         dst_q <= dst_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_RUN;
         halted <= 1'b0;
      end else begin
         unique case (state)
            ST_RUN: begin
               if (issue && is_hlt) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (wb_hlt) begin
                  state  <= ST_HALTED;
                  halted <= 1'b1;
               end
            end
            ST_HALTED: begin
               state  <= ST_HALTED;
               halted <= 1'b1;
            end
            default: begin
               state  <= ST_RUN;
               halted <= 1'b0;
            end
         endcase
      end
   end

   assign ex_valid   = ex_q.valid;
   assign ex_p0      = p0_q;
   assign ex_p1      = p1_q;
   assign ex_link    = ex_q.link;
   assign ex_imm8    = ex_q.imm8;
   assign ex_shamt   = ex_q.shamt;
   assign ex_func    = ex_q.func;
   assign ex_src1sel = ex_q.src1sel;
   assign ex_we_rf   = ex_q.we_rf;
   assign ex_we_mem  = ex_q.we_mem;
   assign ex_re_mem  = ex_q.re_mem;
   assign ex_wb_sel  = ex_q.wb_sel;
   assign ex_hlt     = ex_q.hlt;
   assign ex_dst     = dst_q;

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: per-cycle vector table plus halt/reset
// sequences, run on a 16x16 and a 32x32 instance in lockstep.
module tb_id_pipe;

   typedef struct {
      int vld, ins, pc, wwe, wdst, wdat, mwe, mdst;
      int st, j, jpc, xv, p0, p1, dst, we, re, lk;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic [15:0] if_instr, if_pc;
   logic        wb_we, wb_hlt, mem_we;
   logic [4:0]  wb_dst, mem_dst;
   logic [31:0] wb_data;

   logic        a_stall, a_j, a_xv, a_src1, a_werf, a_wemem;
   logic        a_remem, a_wbsel, a_hlt, a_halted;
   logic [15:0] a_jpc, a_p0, a_p1, a_link;
   logic [7:0]  a_imm8;
   logic [3:0]  a_shamt, a_dst;
   logic [2:0]  a_func;

   logic        b_stall, b_j, b_xv, b_src1, b_werf, b_wemem;
   logic        b_remem, b_wbsel, b_hlt, b_halted;
   logic [15:0] b_jpc, b_link;
   logic [31:0] b_p0, b_p1;
   logic [7:0]  b_imm8;
   logic [3:0]  b_shamt;
   logic [4:0]  b_dst;
   logic [2:0]  b_func;

   int n_err = 0;
   int n_chk = 0;
   vec_t vq[$];

   always #5 clk = ~clk;

   id_pipe #(.DATA_W(16), .NREG(16)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .stall(a_stall), .j_ctrl(a_j), .j_pc(a_jpc),
      .wb_we(wb_we), .wb_dst(wb_dst[3:0]), .wb_data(wb_data[15:0]),
      .wb_hlt(wb_hlt), .mem_we(mem_we), .mem_dst(mem_dst[3:0]),
      .ex_valid(a_xv), .ex_p0(a_p0), .ex_p1(a_p1), .ex_link(a_link),
      .ex_imm8(a_imm8), .ex_shamt(a_shamt), .ex_func(a_func),
      .ex_src1sel(a_src1), .ex_we_rf(a_werf), .ex_we_mem(a_wemem),
      .ex_re_mem(a_remem), .ex_wb_sel(a_wbsel), .ex_hlt(a_hlt),
      .ex_dst(a_dst), .halted(a_halted)
   );

   id_pipe #(.DATA_W(32), .NREG(32)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .stall(b_stall), .j_ctrl(b_j), .j_pc(b_jpc),
      .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
      .wb_hlt(wb_hlt), .mem_we(mem_we), .mem_dst(mem_dst),
      .ex_valid(b_xv), .ex_p0(b_p0), .ex_p1(b_p1), .ex_link(b_link),
      .ex_imm8(b_imm8), .ex_shamt(b_shamt), .ex_func(b_func),
      .ex_src1sel(b_src1), .ex_we_rf(b_werf), .ex_we_mem(b_wemem),
      .ex_re_mem(b_remem), .ex_wb_sel(b_wbsel), .ex_hlt(b_hlt),
      .ex_dst(b_dst), .halted(b_halted)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input int vld, ins, pc, wwe, wdst, wdat,
                               mwe, mdst, st, j, jpc, xv, p0, p1,
                               dst, we, re, lk);
      vec_t v;
      v = '{vld, ins, pc, wwe, wdst, wdat, mwe, mdst,
            st, j, jpc, xv, p0, p1, dst, we, re, lk};
      return v;
   endfunction

   task automatic drive(input int vld, ins, pc);
      if_valid = 1'(vld);
      if_instr = 16'(ins);
      if_pc    = 16'(pc);
      wb_we    = 1'b0;
      wb_dst   = '0;
      wb_data  = '0;
      wb_hlt   = 1'b0;
      mem_we   = 1'b0;
      mem_dst  = '0;
   endtask

   initial begin
      //      vld ins      pc     wwe wd wdat    mwe md
      //      st j jpc     xv p0      p1      dst we re link
      vq.push_back(mk(1, 'h0130, 'h00, 1, 3, 'h1234, 0, 0,
                      0, 0, 0,      1, 'h1234, 0,      1, 1, 0, 'h01));
      vq.push_back(mk(1, 'h0235, 'h01, 1, 5, 'h0055, 0, 0,
                      0, 0, 0,      1, 'h1234, 'h55,   2, 1, 0, 'h02));
      vq.push_back(mk(1, 'h8530, 'h02, 1, 7, 'h0040, 0, 0,
                      0, 0, 0,      1, 'h1234, 0,      5, 1, 1, 'h03));
      vq.push_back(mk(1, 'h0450, 'h03, 0, 0, 0,      0, 0,
                      1, 0, 0,      0, 'h55,   0,      4, 0, 0, 'h04));
      vq.push_back(mk(1, 'h0450, 'h03, 0, 0, 0,      0, 0,
                      0, 0, 0,      1, 'h55,   0,      4, 1, 0, 'h04));
      vq.push_back(mk(1, 'h8030, 'h04, 0, 0, 0,      0, 0,
                      0, 0, 0,      1, 'h1234, 0,      0, 1, 1, 'h05));
      vq.push_back(mk(1, 'h0600, 'h05, 0, 0, 0,      0, 0,
                      0, 0, 0,      1, 0,      0,      6, 1, 0, 'h06));
      vq.push_back(mk(1, 'hDFFE, 'h10, 0, 0, 0,      0, 0,
                      0, 1, 'h0E,   1, 0,      0,     15, 1, 0, 'h11));
      vq.push_back(mk(1, 'h0735, 'h11, 0, 0, 0,      0, 0,
                      0, 0, 0,      1, 'h1234, 'h55,   7, 1, 0, 'h12));
      vq.push_back(mk(1, 'hE070, 'h12, 0, 0, 0,      0, 0,
                      1, 0, 0,      0, 'h40,   0,      0, 0, 0, 'h13));
      vq.push_back(mk(1, 'hE070, 'h12, 0, 0, 0,      1, 7,
                      1, 0, 0,      0, 'h40,   0,      0, 0, 0, 'h13));
      vq.push_back(mk(1, 'hE070, 'h12, 1, 7, 'h1269, 0, 0,
                      0, 1, 'h1269, 1, 'h1269, 0,      0, 0, 0, 'h13));
      vq.push_back(mk(1, 'h8530, 'h13, 0, 0, 0,      0, 0,
                      0, 0, 0,      1, 'h1234, 0,      5, 1, 1, 'h14));
      vq.push_back(mk(0, 'h0450, 'h14, 0, 0, 0,      0, 0,
                      0, 0, 0,      0, 'h55,   0,      4, 0, 0, 'h15));
      vq.push_back(mk(1, 'h0100, 'h15, 1, 0, 'hBEEF, 0, 0,
                      0, 0, 0,      1, 0,      0,      1, 1, 0, 'h16));
      vq.push_back(mk(1, 'h0100, 'h16, 0, 0, 0,      0, 0,
                      0, 0, 0,      1, 0,      0,      1, 1, 0, 'h17));
      vq.push_back(mk(1, 'h9235, 'h17, 0, 0, 0,      0, 0,
                      0, 0, 0,      1, 'h1234, 'h55,   2, 0, 0, 'h18));
      vq.push_back(mk(1, 'hE000, 'h18, 0, 0, 0,      1, 0,
                      0, 1, 0,      1, 0,      0,      0, 0, 0, 'h19));
      vq.push_back(mk(1, 'hE070, 'h19, 0, 0, 0,      1, 7,
                      1, 0, 0,      0, 'h1269, 0,      0, 0, 0, 'h1A));
      vq.push_back(mk(1, 'hE070, 'h19, 0, 0, 0,      0, 0,
                      0, 1, 'h1269, 1, 'h1269, 0,      0, 0, 0, 'h1A));
      vq.push_back(mk(1, 'h8530, 'h20, 0, 0, 0,      0, 0,
                      0, 0, 0,      1, 'h1234, 0,      5, 1, 1, 'h21));
      vq.push_back(mk(1, 'h0405, 'h21, 0, 0, 0,      0, 0,
                      1, 0, 0,      0, 0,      'h55,   4, 0, 0, 'h22));
      vq.push_back(mk(1, 'h0405, 'h21, 0, 0, 0,      0, 0,
                      0, 0, 0,      1, 0,      'h55,   4, 1, 0, 'h22));

      rst_n = 1'b0;
      drive(0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst ex_valid", a_xv, 0);
      chk("rst ex_link", a_link, 0);
      chk("rst ex_we_rf", a_werf, 0);
      chk("rst halted", a_halted, 0);
      chk("rst stall", a_stall, 0);
      chk("rst b ex_valid", b_xv, 0);

      @(negedge clk);
      rst_n = 1'b1;
      foreach (vq[i]) begin
         vec_t v;
         v = vq[i];
         drive(v.vld, v.ins, v.pc);
         wb_we   = 1'(v.wwe);
         wb_dst  = 5'(v.wdst);
         wb_data = 32'(v.wdat);
         mem_we  = 1'(v.mwe);
         mem_dst = 5'(v.mdst);
         #1;
         chk($sformatf("r%0d stall", i), a_stall, v.st);
         chk($sformatf("r%0d j_ctrl", i), a_j, v.j);
         chk($sformatf("r%0d b stall", i), b_stall, v.st);
         if (v.j != 0) begin
            chk($sformatf("r%0d j_pc", i), a_jpc, v.jpc);
            chk($sformatf("r%0d b j_pc", i), b_jpc, v.jpc);
         end
         @(posedge clk);
         #1;
         chk($sformatf("r%0d ex_valid", i), a_xv, v.xv);
         chk($sformatf("r%0d ex_p0", i), a_p0, v.p0);
         chk($sformatf("r%0d ex_p1", i), a_p1, v.p1);
         chk($sformatf("r%0d ex_dst", i), a_dst, v.dst);
         chk($sformatf("r%0d ex_we_rf", i), a_werf, v.we);
         chk($sformatf("r%0d ex_re_mem", i), a_remem, v.re);
         chk($sformatf("r%0d ex_link", i), a_link, v.lk);
         chk($sformatf("r%0d b ex_valid", i), b_xv, v.xv);
         chk($sformatf("r%0d b ex_p0", i), b_p0, v.p0);
         chk($sformatf("r%0d b ex_dst", i), b_dst,
             (v.dst == 15) ? 31 : v.dst);
         @(negedge clk);
      end

      // control-field decode of SW, ALU op 3 and LW
      drive(1, 'h9235, 'h40);
      @(posedge clk); #1;
      chk("sw imm8", a_imm8, 'h35);
      chk("sw shamt", a_shamt, 5);
      chk("sw func", a_func, 0);
      chk("sw src1sel", a_src1, 1);
      chk("sw we_mem", a_wemem, 1);
      chk("sw wb_sel", a_wbsel, 0);
      @(negedge clk);
      drive(1, 'h3123, 'h41);
      @(posedge clk); #1;
      chk("alu func", a_func, 3);
      chk("alu src1sel", a_src1, 0);
      chk("alu we_mem", a_wemem, 0);
      @(negedge clk);
      drive(1, 'h8530, 'h42);
      @(posedge clk); #1;
      chk("lw wb_sel", a_wbsel, 1);
      chk("lw src1sel", a_src1, 1);

      // halt issue, drain with a WB commit, retire, then async reset
      @(negedge clk);
      drive(1, 'hF000, 'h43);
      #1 chk("hlt stall", a_stall, 0);
      @(posedge clk); #1;
      chk("hlt ex_hlt", a_hlt, 1);
      chk("hlt ex_valid", a_xv, 1);
      chk("b hlt ex_hlt", b_hlt, 1);
      @(negedge clk);
      drive(1, 'hDFFE, 'h44);
      #1;
      chk("drain stall", a_stall, 1);
      chk("drain j_ctrl", a_j, 0);
      @(posedge clk); #1;
      chk("drain ex_hlt", a_hlt, 0);
      chk("drain ex_valid", a_xv, 0);
      chk("drain ex_we_rf", a_werf, 0);
      @(negedge clk);
      drive(1, 'h0090, 'h45);
      wb_we = 1'b1; wb_dst = 5'd9; wb_data = 32'h0909;
      @(posedge clk); #1;
      chk("drain wb p0", a_p0, 'h0909);
      chk("drain halted", a_halted, 0);
      @(negedge clk);
      drive(1, 'h0090, 'h45);
      wb_hlt = 1'b1;
      @(posedge clk); #1;
      chk("halted set", a_halted, 1);
      chk("b halted set", b_halted, 1);
      @(negedge clk);
      drive(1, 'h0090, 'h45);
      #1 chk("halted stall", a_stall, 1);
      @(posedge clk); #1;
      chk("halted hold", a_halted, 1);
      chk("halted ex_valid", a_xv, 0);
      chk("halted rf p0", a_p0, 'h0909);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid rst halted", a_halted, 0);
      chk("mid rst ex_p0", a_p0, 0);
      chk("mid rst ex_link", a_link, 0);
      chk("mid rst stall", a_stall, 0);
      chk("b mid rst halted", b_halted, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post rst ex_valid", a_xv, 1);
      chk("post rst rf p0", a_p0, 0);
      chk("post rst halted", a_halted, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
